cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling controller that sits downstream of the multi-cycle memory and its latency counter. On a cache miss it issues one read per cycle for the 8 words of the missed block. It consumes each returned word as the memory flags it valid, steering it into the cache data array. After the final word it writes the tag and releases the pipeline stall.

Parameters:
WORDS, 8, words per cache block (power of two; index width log2(WORDS)=3)
ADDR_W, 16, byte address width
DATA_W, 16, word width (2 bytes per word)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  ADDR_W  byte address of the missing access
memory_data_valid  input  1  memory returns a valid word this cycle
memory_data  input  DATA_W  returned word
fsm_busy  output  1  fill in progress; pipeline stalls while high
mem_read_en  output  1  read request to memory this cycle
memory_address  output  ADDR_W  byte address of the current request
write_data_array  output  1  write memory_data into the data array this cycle
word_sel  output  3  destination word index within the block
write_tag_array  output  1  one-cycle pulse: write tag/valid for the block

Behaviour:
- Reset: all flops clear asynchronously on rst_n low. State=IDLE, base=0, issue_cnt=0, recv_cnt=0. All outputs 0.
- States:
  - IDLE to FILL on miss_detected; in the same edge capture base = miss_address with bits [3:0] cleared, and clear both counters.
  - FILL to IDLE on the edge after the 8th valid word is accepted.
- fsm_busy = (state==FILL). It goes high the cycle after miss_detected and stays high through the cycle carrying the 8th word.
- Issue side (FILL only):
  - mem_read_en = (issue_cnt < 8).
  - memory_address = base + 2*issue_cnt.
  - issue_cnt increments each cycle mem_read_en is high and saturates at 8 (4-bit counter).
  - First request: address base, in the first FILL cycle.
- Receive side (FILL only):
  - write_data_array = memory_data_valid.
  - word_sel = recv_cnt[2:0].
  - recv_cnt increments on each accepted valid.
  - write_tag_array = memory_data_valid & (recv_cnt==7), i.e. the same cycle as the last data write.
- Fill length with a 4-cycle memory: 8 issue cycles plus 4-cycle tail, so fsm_busy is high for 12 cycles.
- Boundary conditions:
  - miss_detected while in FILL: ignored, base is not recaptured.
  - memory_data_valid in IDLE: ignored, no writes.
  - The final issue and a receive in the same cycle are independent and both take effect.
  - Receives without gaps are allowed; idle (non-valid) cycles between receives are tolerated.
  - No more than 8 words are accepted per fill; recv_cnt never exceeds 8.
  - rst_n asserted mid-fill: immediate return to IDLE. Any partial block stays invalid because write_tag_array is never pulsed.
  - Address arithmetic is modulo 2^ADDR_W. Block base 0xFFF0 issues 0xFFF0..0xFFFE with no carry out.
- mem_read_en, write_data_array and write_tag_array are combinational from state, counters and inputs; all state is registered.

Optional Feature:
Macro: FILL_CRITICAL_FIRST_EN.
- Defined: on entry to FILL, capture start = miss_address[3:1]. Requests go to base + 2*((start+issue_cnt) mod 8), and word_sel = (start+recv_cnt) mod 8, so the missed word arrives first and indices wrap 7→0. All other timing is unchanged.
- Undefined: start is absent and ordering is sequential from word 0, as above.

Test Plan:
- Reset mid-fill: assert rst_n=0 at cycle 5 of a fill → fsm_busy, mem_read_en, write_* all 0 immediately. No write_tag_array pulse. Next miss restarts at word 0.
- Basic fill: miss_address=0x1236, memory valid 4 cycles after each request →
  - requests 0x1230,0x1232,...,0x123E on consecutive cycles;
  - data writes word_sel 0..7;
  - write_tag_array pulses once with word 7;
  - fsm_busy high exactly 12 cycles.
- Miss while busy: pulse miss_detected with miss_address=0x4000 at FILL cycle 3 → no effect; all addresses remain in 0x1230 block.
- Gapped returns: valid delivered on cycles 4,6,9,10,13,14,15,17 → word_sel 0..7 in order; fsm_busy drops the cycle after cycle 17.
- Wrap/boundary: miss_address=0xFFFA → addresses 0xFFF0..0xFFFE. With FILL_CRITICAL_FIRST_EN, order is 0xFFFA,0xFFFC,0xFFFE,0xFFF0,...,0xFFF8 and word_sel 5,6,7,0,1,2,3,4.

Source files
------------

// File: rtl/cache_fill_if.sv
// rtl/cache_fill_if.sv - miss request, memory return and array-write signals of the fill controller

interface cache_fill_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_sel;
  logic              write_tag_array;

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_data_array, word_sel, write_tag_array
  );

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_data_array, word_sel, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller; FILL_CRITICAL_FIRST_EN enables critical-word-first order
// Issues one word read per cycle for the missed block and steers returned words into the data array.

module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  cache_fill_if.slave bus
);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
`ifdef FILL_CRITICAL_FIRST_EN
  logic [IDX_W-1:0]  start_q, start_d;
`endif

  logic              in_fill;
  logic              rd_en;
  logic              accept;
  logic              last_word;
  logic [IDX_W-1:0]  issue_idx;
  logic [IDX_W-1:0]  recv_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
`ifdef FILL_CRITICAL_FIRST_EN
      start_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
`ifdef FILL_CRITICAL_FIRST_EN
      start_q     <= start_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
`ifdef FILL_CRITICAL_FIRST_EN
    start_d     = start_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.miss_detected) begin
          state_d     = S_FILL;
          base_d      = {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
`ifdef FILL_CRITICAL_FIRST_EN
          start_d     = bus.miss_address[OFF_W-1:1];
`endif
        end
      end
      S_FILL: begin
        // Issue and receive counters advance independently; a miss here is ignored.
        if (rd_en)  issue_cnt_d = issue_cnt_q + 1'b1;
        if (accept) recv_cnt_d  = recv_cnt_q + 1'b1;
        if (last_word) state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_fill   = (state_q == S_FILL);
    rd_en     = in_fill && (issue_cnt_q < CNT_FULL);
    accept    = in_fill && bus.memory_data_valid && (recv_cnt_q < CNT_FULL);
    last_word = accept && (recv_cnt_q == CNT_LAST);
`ifdef FILL_CRITICAL_FIRST_EN
    issue_idx = issue_cnt_q[IDX_W-1:0] + start_q;
    recv_idx  = recv_cnt_q[IDX_W-1:0] + start_q;
`else
    issue_idx = issue_cnt_q[IDX_W-1:0];
    recv_idx  = recv_cnt_q[IDX_W-1:0];
`endif

    bus.fsm_busy         = in_fill;
    bus.mem_read_en      = rd_en;
    // Base has its offset bits clear, so concatenation equals base + 2*idx with no carry.
    bus.memory_address   = rd_en ? {base_q[ADDR_W-1:OFF_W], issue_idx, 1'b0} : '0;
    bus.write_data_array = accept;
    bus.word_sel         = in_fill ? recv_idx : '0;
    bus.write_tag_array  = last_word;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized self-checking bench for cache_fill_fsm against a per-fill schedule model

module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   vsched[8];

  always #5 clk = ~clk;

  cache_fill_if #(.ADDR_W(16), .DATA_W(16), .IDX_W(3)) bus ();

  cache_fill_fsm #(.WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, "_busy"}, 32'(bus.fsm_busy), 32'd0);
    chk_eq({tag, "_rd"},   32'(bus.mem_read_en), 32'd0);
    chk_eq({tag, "_wr"},   32'(bus.write_data_array), 32'd0);
    chk_eq({tag, "_tag"},  32'(bus.write_tag_array), 32'd0);
  endtask

  // Returns on fill cycles v[k] after a fixed latency from request k.
  task automatic sched_fixed(input int lat);
    for (int k = 0; k < 8; k++) vsched[k] = k + lat;
  endtask

  task automatic sched_random();
    int t;
    t = 1 + int'($urandom_range(0, 4));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) t = vsched[k-1] + 1 + int'($urandom_range(0, 2));
      if (t < k + 1) t = k + 1;
      vsched[k] = t;
    end
  endtask

  // One whole fill: miss cycle, then fill cycles 0..vsched[7]+1 checked against the model.
  task automatic run_fill(input logic [15:0] addr, input int miss_at, input logic [15:0] miss2,
                          input int rst_at);
    logic [15:0] base;
    logic [15:0] exp_addr;
    int st;
    int k;
    int end_c;
    base = {addr[15:4], 4'h0};
`ifdef FILL_CRITICAL_FIRST_EN
    st = int'(addr[3:1]);
`else
    st = 0;
`endif
    end_c = vsched[7] + 1;
    @(negedge clk);
    bus.miss_detected     = 1'b1;
    bus.miss_address      = addr;
    bus.memory_data_valid = 1'($urandom_range(0, 1));
    bus.memory_data       = 16'($urandom);
    #1;
    chk_quiet("miss_cycle");
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      k = -1;
      for (int j = 0; j < 8; j++) if (vsched[j] == c) k = j;
      bus.miss_detected     = (c == miss_at);
      bus.miss_address      = (c == miss_at) ? miss2 : 16'($urandom);
      bus.memory_data_valid = (k >= 0) || ((c == end_c) && ($urandom_range(0, 1) == 1));
      bus.memory_data       = 16'($urandom);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        chk_eq("rst_mid_sel", 32'(bus.word_sel), 32'd0);
        @(negedge clk);
        chk_quiet("rst_hold");
        bus.miss_detected     = 1'b0;
        bus.memory_data_valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
      #1;
      chk_eq("busy", 32'(bus.fsm_busy), 32'(c < end_c));
      chk_eq("rd_en", 32'(bus.mem_read_en), 32'(c < 8));
      if (c < 8) begin
        exp_addr = base + 16'(2 * ((st + c) % 8));
        chk_eq("addr", 32'(bus.memory_address), 32'(exp_addr));
      end
      chk_eq("wr_data", 32'(bus.write_data_array), 32'(k >= 0));
      if (k >= 0) chk_eq("word_sel", 32'(bus.word_sel), 32'((st + k) % 8));
      chk_eq("wr_tag", 32'(bus.write_tag_array), 32'(k == 7));
    end
    @(negedge clk);
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b0;
  endtask

  initial begin
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    #2;
    chk_quiet("reset");
    chk_eq("reset_addr", 32'(bus.memory_address), 32'd0);
    chk_eq("reset_sel", 32'(bus.word_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle valid with no miss must not write.
    @(negedge clk);
    bus.memory_data_valid = 1'b1;
    #1;
    chk_quiet("idle_valid");
    bus.memory_data_valid = 1'b0;

    sched_fixed(4);
    run_fill(16'h1236, -1, 16'h0000, -1);
    run_fill(16'h1236, 3, 16'h4000, -1);

    vsched[0] = 4;  vsched[1] = 6;  vsched[2] = 9;  vsched[3] = 10;
    vsched[4] = 13; vsched[5] = 14; vsched[6] = 15; vsched[7] = 17;
    run_fill(16'h1236, -1, 16'h0000, -1);

    sched_fixed(4);
    run_fill(16'hFFFA, -1, 16'h0000, -1);

    run_fill(16'h2348, -1, 16'h0000, 5);
    sched_fixed(4);
    run_fill(16'h0000, -1, 16'h0000, -1);

    for (int n = 0; n < 30; n++) begin
      sched_random();
      run_fill(16'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1,
               16'($urandom),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
